// File: rtl/pipelined_barrelshifter.sv
// pipelined_barrelshifter
//   Pipelined shift/rotate unit. The log2(D_SIZE)-deep mux tree is split into
//   one registered stage per shift-amount bit. All stages advance together
//   under a valid/ready handshake with full backpressure. Throughput is one
//   operation per cycle and latency is L = $clog2(D_SIZE) cycles.
//
//   Operations (op_in): 000 LSR, 001 ASR, 01x ROR, 100 LSL, 101 ASL, 11x ROL.
//   The ASL overflow flag is computed once, at acceptance, and carried down
//   the pipe alongside the data.
//
//   Build option: define BSHIFT_ASL_SAT_EN to saturate the ASL result on
//   overflow (0111..1 for a positive operand, 1000..0 for a negative one).
//
// Ports
//   clk_in       clock, rising edge
//   rst_n_in     asynchronous active-low reset
//   x_valid_in   operand valid
//   x_ready_out  operand accepted when x_valid_in && x_ready_out
//   x_in         operand, D_SIZE bits
//   s_in         shift amount, L bits
//   op_in        operation code, 3 bits
//   y_valid_out  result valid
//   y_ready_in   result consumed when y_valid_out && y_ready_in
//   y_out        result, D_SIZE bits
//   zf_out       y_out == 0
//   vf_out       ASL overflow
module pipelined_barrelshifter #(
  parameter int unsigned D_SIZE = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       x_valid_in,
  output logic                       x_ready_out,
  input  logic [D_SIZE-1:0]          x_in,
  input  logic [$clog2(D_SIZE)-1:0]  s_in,
  input  logic [2:0]                 op_in,
  output logic                       y_valid_out,
  input  logic                       y_ready_in,
  output logic [D_SIZE-1:0]          y_out,
  output logic                       zf_out,
  output logic                       vf_out
);

  localparam int unsigned L = $clog2(D_SIZE);

  localparam logic [2:0] OP_ASR = 3'b001;
  localparam logic [2:0] OP_ASL = 3'b101;

  // Refuse to elaborate for widths that are not a power of two >= 2.
  if ((D_SIZE < 2) || ((D_SIZE & (D_SIZE - 1)) != 0)) begin : g_bad_d_size
    $error("pipelined_barrelshifter: D_SIZE must be a power of two >= 2");
  end

  // Stage inputs (index k = input of stage k)
  logic [L-1:0][D_SIZE-1:0] in_data;
  logic [L-1:0][L-1:0]      in_s;
  logic [L-1:0][2:0]        in_op;
  logic [L-1:0]             in_sign;
  logic [L-1:0]             in_vf;
  logic [L-1:0]             in_valid;

  // Stage registers and their next-state values
  logic [L-1:0][D_SIZE-1:0] data_q, data_d;
  logic [L-1:0][L-1:0]      s_q, s_d;
  logic [L-1:0][2:0]        op_q, op_d;
  logic [L-1:0]             sign_q, sign_d;
  logic [L-1:0]             vf_q, vf_d;
  logic [L-1:0]             valid_q, valid_d;
  logic                     zf_q, zf_d;

  logic                     advance;
  logic [D_SIZE-1:0]        sh;

  // Shift/rotate by a fixed power-of-two amount. The operand is placed in a
  // double-width word together with its fill (or a copy of itself for
  // rotates) so one shift covers every operation.
  function automatic logic [D_SIZE-1:0] stage_shift(
    input logic [D_SIZE-1:0] d,
    input logic [2:0]        op,
    input logic              sign,
    input int unsigned       amt
  );
    logic [2*D_SIZE-1:0] w;
    logic [D_SIZE-1:0]   fill;
    fill = (op == OP_ASR) ? {D_SIZE{sign}} : '0;
    if (!op[2]) begin
      w = op[1] ? {d, d} : {fill, d};
      w = w >> amt;
      stage_shift = w[D_SIZE-1:0];
    end else begin
      w = op[1] ? {d, d} : {d, {D_SIZE{1'b0}}};
      w = w << amt;
      stage_shift = w[2*D_SIZE-1:D_SIZE];
    end
  endfunction

  // ASL overflows when any bit shifted through the sign position differs
  // from the sign, i.e. x[D_SIZE-2 : D_SIZE-1-s] != x[D_SIZE-1].
  function automatic logic asl_overflow(
    input logic [D_SIZE-1:0] x,
    input logic [L-1:0]      s
  );
    asl_overflow = 1'b0;
    for (int unsigned i = 0; i < D_SIZE - 1; i++) begin
      if ((i + 32'(s) >= D_SIZE - 1) && (x[i] != x[D_SIZE-1]))
        asl_overflow = 1'b1;
    end
  endfunction

  assign advance = !valid_q[L-1] || y_ready_in;

  assign in_data[0]  = x_in;
  assign in_s[0]     = s_in;
  assign in_op[0]    = op_in;
  assign in_sign[0]  = x_in[D_SIZE-1];
  assign in_vf[0]    = (op_in == OP_ASL) && asl_overflow(x_in, s_in);
  assign in_valid[0] = x_valid_in;

  for (genvar k = 1; k < L; k++) begin : g_link
    assign in_data[k]  = data_q[k-1];
    assign in_s[k]     = s_q[k-1];
    assign in_op[k]    = op_q[k-1];
    assign in_sign[k]  = sign_q[k-1];
    assign in_vf[k]    = vf_q[k-1];
    assign in_valid[k] = valid_q[k-1];
  end

  always_comb begin
    data_d  = '0;
    s_d     = '0;
    op_d    = '0;
    sign_d  = '0;
    vf_d    = '0;
    valid_d = '0;
    zf_d    = 1'b0;
    sh      = '0;
    for (int unsigned k = 0; k < L; k++) begin
      sh = in_data[k];
      if (in_s[k][k])
        sh = stage_shift(in_data[k], in_op[k], in_sign[k], 32'd1 << k);
      if (k == L - 1) begin
        // ASL runs as a plain left shift through the pipe; the sign bit is
        // restored only at the end since it never feeds lower bits.
        if (in_op[k] == OP_ASL)
          sh[D_SIZE-1] = in_sign[k];
`ifdef BSHIFT_ASL_SAT_EN
        if (in_vf[k])
          sh = in_sign[k] ? {1'b1, {(D_SIZE-1){1'b0}}}
                          : {1'b0, {(D_SIZE-1){1'b1}}};
`endif
        zf_d = (sh == '0);
      end
      data_d[k]  = sh;
      s_d[k]     = in_s[k];
      op_d[k]    = in_op[k];
      sign_d[k]  = in_sign[k];
      vf_d[k]    = in_vf[k];
      valid_d[k] = in_valid[k];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_q  <= '0;
      s_q     <= '0;
      op_q    <= '0;
      sign_q  <= '0;
      vf_q    <= '0;
      valid_q <= '0;
      zf_q    <= 1'b0;
    end else if (advance) begin
      data_q  <= data_d;
      s_q     <= s_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      vf_q    <= vf_d;
      valid_q <= valid_d;
      zf_q    <= zf_d;
    end
  end

  // Control fields of the last stage have no consumer; the tools prune them.
  logic unused_tail;
  assign unused_tail = ^{s_q[L-1], op_q[L-1], sign_q[L-1]};

  assign x_ready_out = advance;
  assign y_valid_out = valid_q[L-1];
  assign y_out       = data_q[L-1];
  assign zf_out      = zf_q;
  assign vf_out      = vf_q[L-1];

endmodule

// File: tb/tb_pipelined_barrelshifter.sv
module tb_pipelined_barrelshifter;

  localparam int D = 8;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       x_valid_in;
  logic       x_ready_out;
  logic [7:0] x_in;
  logic [2:0] s_in;
  logic [2:0] op_in;
  logic       y_valid_out;
  logic       y_ready_in;
  logic [7:0] y_out;
  logic       zf_out;
  logic       vf_out;

  pipelined_barrelshifter #(.D_SIZE(D)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .x_valid_in  (x_valid_in),
    .x_ready_out (x_ready_out),
    .x_in        (x_in),
    .s_in        (s_in),
    .op_in       (op_in),
    .y_valid_out (y_valid_out),
    .y_ready_in  (y_ready_in),
    .y_out       (y_out),
    .zf_out      (zf_out),
    .vf_out      (vf_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] y;
    logic       zf;
    logic       vf;
  } res_t;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] x;
    logic [2:0] s;
    logic [7:0] y;
    logic       zf;
    logic       vf;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   out_cnt = 0;
  res_t exp_q[$];

`ifdef BSHIFT_ASL_SAT_EN
  localparam logic [7:0] ASL_OVF_Y = 8'h7F;
`else
  localparam logic [7:0] ASL_OVF_Y = 8'h70;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operand.
  function automatic res_t model(input logic [7:0] x, input logic [2:0] s, input logic [2:0] op);
    res_t r;
    int xi, sx, si, prod;
    xi = int'(x);
    sx = int'($signed(x));
    si = int'(s);
    r.vf = 1'b0;
    case (op)
      3'd0:       r.y = 8'(xi >> si);
      3'd1:       r.y = 8'(sx >>> si);
      3'd2, 3'd3: r.y = 8'((xi >> si) | (xi << (8 - si)));
      3'd4:       r.y = 8'(xi << si);
      3'd5: begin
        prod = sx * (1 << si);
        r.vf = (prod > 127) || (prod < -128);
        r.y  = {x[7], 7'(xi << si)};
`ifdef BSHIFT_ASL_SAT_EN
        if (r.vf) r.y = x[7] ? 8'h80 : 8'h7F;
`endif
      end
      default:    r.y = 8'((xi << si) | (xi >> (8 - si)));
    endcase
    r.zf = (r.y == 8'h00);
    return r;
  endfunction

  // Scoreboard: predict on acceptance, compare on consumption.
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1) begin
      if (y_valid_out && y_ready_in) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("sb_y", 32'(y_out), 32'(e.y));
          check("sb_zf", 32'(zf_out), 32'(e.zf));
          check("sb_vf", 32'(vf_out), 32'(e.vf));
        end
        out_cnt++;
      end
      if (x_valid_in && x_ready_out)
        exp_q.push_back(model(x_in, s_in, op_in));
    end
  end

  // Issue one op into an idle pipe (called at posedge+1) and check its
  // latency and result against the given expectation.
  task automatic run_vec(input vec_t v);
    int lat;
    x_valid_in = 1'b1;
    x_in       = v.x;
    s_in       = v.s;
    op_in      = v.op;
    @(posedge clk_in); #1;
    x_valid_in = 1'b0;
    lat = 1;
    while (!y_valid_out && lat < 12) begin
      @(posedge clk_in); #1;
      lat++;
    end
    check({v.name, "_latency"}, 32'(lat), 32'd3);
    check({v.name, "_y"}, 32'(y_out), 32'(v.y));
    check({v.name, "_zf"}, 32'(zf_out), 32'(v.zf));
    check({v.name, "_vf"}, 32'(vf_out), 32'(v.vf));
  endtask

  vec_t       tbl[12];
  logic [7:0] sx_v[8];
  logic [2:0] ss_v[8];
  logic [2:0] so_v[8];
  logic [9:0] held;
  int         issued, gaps, base;
  logic       acc;

  initial begin
    tbl[0]  = '{"lsr_b4_3",   3'd0, 8'hB4, 3'd3, 8'h16,     1'b0, 1'b0};
    tbl[1]  = '{"asr_b4_2",   3'd1, 8'hB4, 3'd2, 8'hED,     1'b0, 1'b0};
    tbl[2]  = '{"ror_01_1",   3'd2, 8'h01, 3'd1, 8'h80,     1'b0, 1'b0};
    tbl[3]  = '{"rol_81_1",   3'd6, 8'h81, 3'd1, 8'h03,     1'b0, 1'b0};
    tbl[4]  = '{"lsl_80_1",   3'd4, 8'h80, 3'd1, 8'h00,     1'b1, 1'b0};
    tbl[5]  = '{"asl_0f_4",   3'd5, 8'h0F, 3'd4, ASL_OVF_Y, 1'b0, 1'b1};
    tbl[6]  = '{"asl_f0_3",   3'd5, 8'hF0, 3'd3, 8'h80,     1'b0, 1'b0};
    tbl[7]  = '{"asr_s0",     3'd1, 8'h5A, 3'd0, 8'h5A,     1'b0, 1'b0};
    tbl[8]  = '{"asl_s0",     3'd5, 8'hC3, 3'd0, 8'hC3,     1'b0, 1'b0};
    tbl[9]  = '{"ror11_s0",   3'd3, 8'h96, 3'd0, 8'h96,     1'b0, 1'b0};
    tbl[10] = '{"rol_3c_4",   3'd7, 8'h3C, 3'd4, 8'hC3,     1'b0, 1'b0};
    tbl[11] = '{"lsr_01_1",   3'd0, 8'h01, 3'd1, 8'h00,     1'b1, 1'b0};

    rst_n_in   = 1'b0;
    x_valid_in = 1'b0;
    x_in       = '0;
    s_in       = '0;
    op_in      = '0;
    y_ready_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_y_valid", 32'(y_valid_out), 32'd0);
    check("rst_y", 32'(y_out), 32'd0);
    check("rst_zf", 32'(zf_out), 32'd0);
    check("rst_vf", 32'(vf_out), 32'd0);
    check("rst_x_ready", 32'(x_ready_out), 32'd1);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Directed table
    for (int i = 0; i < 12; i++) run_vec(tbl[i]);
    @(posedge clk_in); #1;

    // Eight back-to-back ops with a 4-cycle output stall mid-stream
    for (int i = 0; i < 8; i++) begin
      sx_v[i] = 8'($urandom);
      ss_v[i] = 3'($urandom_range(1, 7));
      so_v[i] = 3'(i);
    end
    issued = 0;
    gaps   = 0;
    base   = out_cnt;
    held   = '0;
    for (int c = 0; c < 40 && (out_cnt - base) < 8; c++) begin
      y_ready_in = !(c >= 5 && c <= 8);
      if (issued < 8) begin
        x_valid_in = 1'b1;
        x_in       = sx_v[issued];
        s_in       = ss_v[issued];
        op_in      = so_v[issued];
      end else begin
        x_valid_in = 1'b0;
      end
      #1;
      if (c == 5) begin
        check("stall_y_valid", 32'(y_valid_out), 32'd1);
        check("stall_x_ready_drop", 32'(x_ready_out), 32'd0);
        held = {y_out, zf_out, vf_out};
      end
      if (c > 5 && c <= 8)
        check("stall_hold", 32'({y_out, zf_out, vf_out}), 32'(held));
      if (c >= 9 && !y_valid_out) gaps++;
      acc = x_valid_in && x_ready_out;
      @(posedge clk_in); #1;
      if (acc) issued++;
    end
    x_valid_in = 1'b0;
    y_ready_in = 1'b1;
    check("stall_issued", 32'(issued), 32'd8);
    check("stall_results", 32'(out_cnt - base), 32'd8);
    check("stall_resume_gaps", 32'(gaps), 32'd0);

    // Randomised traffic with random backpressure and bubbles
    for (int c = 0; c < 600; c++) begin
      x_valid_in = ($urandom_range(0, 3) != 0);
      x_in       = 8'($urandom);
      s_in       = 3'($urandom);
      op_in      = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom);
      y_ready_in = ($urandom_range(0, 3) != 0);
      @(posedge clk_in); #1;
    end
    x_valid_in = 1'b0;
    y_ready_in = 1'b1;
    repeat (6) @(posedge clk_in);
    #1;
    check("random_drained", 32'(exp_q.size()), 32'd0);
    check("random_idle_valid", 32'(y_valid_out), 32'd0);

    // Asynchronous reset with three ops in flight
    x_valid_in = 1'b1; x_in = 8'h0F; s_in = 3'd4; op_in = 3'd5;
    @(posedge clk_in); #1;
    x_in = 8'hFF; s_in = 3'd1; op_in = 3'd0;
    @(posedge clk_in); #1;
    x_in = 8'h81; s_in = 3'd1; op_in = 3'd6;
    @(posedge clk_in); #1;
    x_valid_in = 1'b0;
    check("inflight_y_valid", 32'(y_valid_out), 32'd1);
    check("inflight_vf", 32'(vf_out), 32'd1);
    #1;
    rst_n_in = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_y_valid", 32'(y_valid_out), 32'd0);
    check("async_rst_y", 32'(y_out), 32'd0);
    check("async_rst_zf", 32'(zf_out), 32'd0);
    check("async_rst_vf", 32'(vf_out), 32'd0);
    #3;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    base = out_cnt;
    for (int c = 0; c < 5; c++) begin
      check("post_rst_no_stale", 32'(y_valid_out), 32'd0);
      @(posedge clk_in); #1;
    end
    check("post_rst_no_output", 32'(out_cnt - base), 32'd0);
    run_vec('{"post_rst_asr", 3'd1, 8'h80, 3'd7, 8'hFF, 1'b0, 1'b0});
    @(posedge clk_in); #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
